trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Sequences machine-mode trap entry and return around the CSR block for the single-issue core.
- Arbitrates between a synchronous exception, an mret and a pending interrupt, then drains outstanding memory activity.
- Drives the CSR hardware-write strobe and values for mepc/mcause, computes the redirect PC from mtvec or mepc, and stalls fetch until the redirect is accepted.

Parameters:
XLEN, 32, data/address width; matches CSR.

Ports:
clk  input  1  clock
rst_b  input  1  reset, asynchronous, active-low
exc_valid  input  1  one-cycle pulse: current instruction raised an exception
exc_code  input  XLEN-1  exception code for exc_valid
exc_pc  input  XLEN  PC of the faulting instruction
mret_valid  input  1  one-cycle pulse: mret retiring
irq_valid  input  1  level: machine interrupt pending and enabled
irq_code  input  XLEN-1  interrupt code for irq_valid
next_pc  input  XLEN  PC of next unexecuted instruction; saved on interrupt
pipe_busy  input  1  LSU/bus has outstanding transactions
csr_rd_mtvec_base  input  XLEN-2  mtvec.base from CSR
csr_rd_mtvec_mode  input  2  mtvec.mode from CSR
csr_rd_mepc_mepc  input  XLEN  mepc from CSR
ent_trap  output  1  CSR HW-write strobe for mepc/mcause
csr_wr_mepc_mepc  output  XLEN  value written to mepc
csr_wr_mcause_exception_code  output  XLEN-1  value written to mcause code
csr_wr_mcause_interrupt  output  1  value written to mcause interrupt bit
redirect_valid  output  1  redirect request to fetch
redirect_pc  output  XLEN  redirect target
redirect_ready  input  1  fetch accepts redirect
stall  output  1  hold fetch/issue; high whenever state != IDLE

Behaviour:
- Reset (async, rst_b low): state=IDLE. All outputs 0. Captured cause/pc/kind registers 0. Reset mid-sequence aborts immediately, with no ent_trap and no redirect.
- States: IDLE, DRAIN, SAVE, JUMP, RETURN.
- IDLE, request priority when multiple are present in the same cycle: exc_valid > mret_valid > irq_valid.
  - Exception: capture pc=exc_pc, code=exc_code, intr=0.
  - Interrupt: capture pc=next_pc, code=irq_code, intr=1.
  - Mret: capture kind=RET.
  - Any accepted request moves to DRAIN.
  - A lower-priority exc/mret pulse lost in the same cycle is dropped; the core guarantees this cannot happen.
  - An interrupt loses arbitration silently and is re-evaluated when the FSM next sits in IDLE, since irq_valid is a level.
- DRAIN: stay while pipe_busy=1. When pipe_busy=0, go to SAVE (trap) or RETURN (mret). Minimum one cycle.
- SAVE:
  - ent_trap=1 for exactly one cycle.
  - csr_wr_mepc_mepc = captured pc with bits[1:0] forced 0.
  - csr_wr_mcause_interrupt = intr; csr_wr_mcause_exception_code = code.
  - The data outputs are valid only while ent_trap=1 and are driven 0 otherwise.
  - Next state JUMP.
- JUMP:
  - redirect_valid=1; redirect_pc = {csr_rd_mtvec_base, 2'b00}, sampled in JUMP so the CSR write from SAVE is settled.
  - Hold redirect_valid and redirect_pc stable until redirect_ready=1, then go to IDLE.
- RETURN:
  - redirect_valid=1; redirect_pc = {csr_rd_mepc_mepc[XLEN-1:2], 2'b00}.
  - Hold until redirect_ready=1, then go to IDLE.
- Latency with pipe_busy=0 and redirect_ready=1:
  - Trap: accept cycle 0, ent_trap cycle 2, redirect cycle 3, IDLE cycle 4.
  - Mret: redirect cycle 2, IDLE cycle 3.
- stall = (state != IDLE); it is registered, so it rises the cycle after accept.
- exc_valid/mret_valid arriving while state != IDLE are ignored; the core cannot issue while stall=1.
- Address arithmetic is modulo 2^XLEN; wrap-around is not flagged.
- mtvec.mode values 2 and 3 (reserved) are treated as direct.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: in JUMP, if mode==1 and intr==1, redirect_pc = {base,2'b00} + (code << 2), truncated to XLEN. Exceptions always use base.
- Undefined: mode is ignored and all traps go to {base,2'b00}.

Test Plan:
- mtvec=0x8000_0100 direct; exc_valid with code=11, exc_pc=0x8000_0040, pipe_busy=0, redirect_ready=1 -> ent_trap at cycle 2 with mepc=0x8000_0040, mcause={0,11}; redirect_pc=0x8000_0100 at cycle 3; stall high for cycles 1-3.
- Same as above but pipe_busy=1 for 5 cycles after accept -> FSM stays in DRAIN 5 extra cycles; ent_trap delayed by 5.
- mepc=0x8000_0044, mret_valid -> redirect_pc=0x8000_0044 at cycle 2; ent_trap never asserts.
- exc_valid, mret_valid and irq_valid high together -> exception serviced; irq (code 7) serviced after return to IDLE with mepc=next_pc and mcause interrupt=1.
- With TRAP_VECTORED_EN, mtvec=0x8000_0101, irq code 7 -> redirect_pc=0x8000_011C; without the macro -> 0x8000_0100.
- redirect_ready held low 4 cycles in JUMP -> redirect_valid and redirect_pc stable; rst_b asserted mid-JUMP -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/trap_ctrl_if.sv
// Request/CSR/redirect bundle between trap_ctrl and the core, CSR block and fetch.
// master = trap_ctrl, slave = the surrounding core.
interface trap_ctrl_if #(
   parameter int XLEN = 32
);
   logic            exc_valid;
   logic [XLEN-2:0] exc_code;
   logic [XLEN-1:0] exc_pc;
   logic            mret_valid;
   logic            irq_valid;
   logic [XLEN-2:0] irq_code;
   logic [XLEN-1:0] next_pc;
   logic            pipe_busy;
   logic [XLEN-3:0] csr_rd_mtvec_base;
   logic [1:0]      csr_rd_mtvec_mode;
   logic [XLEN-1:0] csr_rd_mepc_mepc;
   logic            ent_trap;
   logic [XLEN-1:0] csr_wr_mepc_mepc;
   logic [XLEN-2:0] csr_wr_mcause_exception_code;
   logic            csr_wr_mcause_interrupt;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            redirect_ready;
   logic            stall;

   modport master (
      input  exc_valid, exc_code, exc_pc, mret_valid, irq_valid, irq_code, next_pc,
             pipe_busy, csr_rd_mtvec_base, csr_rd_mtvec_mode, csr_rd_mepc_mepc,
             redirect_ready,
      output ent_trap, csr_wr_mepc_mepc, csr_wr_mcause_exception_code,
             csr_wr_mcause_interrupt, redirect_valid, redirect_pc, stall
   );

   modport slave (
      output exc_valid, exc_code, exc_pc, mret_valid, irq_valid, irq_code, next_pc,
             pipe_busy, csr_rd_mtvec_base, csr_rd_mtvec_mode, csr_rd_mepc_mepc,
             redirect_ready,
      input  ent_trap, csr_wr_mepc_mepc, csr_wr_mcause_exception_code,
             csr_wr_mcause_interrupt, redirect_valid, redirect_pc, stall
   );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / mret sequencer: arbitrate, drain, write mepc/mcause, redirect fetch.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt targets (mtvec.mode == 1).
module trap_ctrl #(
   parameter int XLEN = 32
) (
   input  logic         clk,
   input  logic         rst_b,
   trap_ctrl_if.master  bus
);
   typedef enum logic [2:0] {IDLE, DRAIN, SAVE, JUMP, RETURN} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-2:0] code_q, code_d;
   logic            intr_q, intr_d;
   logic            ret_q, ret_d;
   logic            stall_q, stall_d;

   logic            ent_trap;
   logic [XLEN-1:0] mepc_wr;
   logic [XLEN-2:0] code_wr;
   logic            intr_wr;
   logic            rvalid;
   logic [XLEN-1:0] rpc;
   logic [XLEN-1:0] trap_tgt;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= IDLE;
         pc_q    <= '0;
         code_q  <= '0;
         intr_q  <= 1'b0;
         ret_q   <= 1'b0;
         stall_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         code_q  <= code_d;
         intr_q  <= intr_d;
         ret_q   <= ret_d;
         stall_q <= stall_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      code_d   = code_q;
      intr_d   = intr_q;
      ret_d    = ret_q;
      ent_trap = 1'b0;
      mepc_wr  = '0;
      code_wr  = '0;
      intr_wr  = 1'b0;
      rvalid   = 1'b0;
      rpc      = '0;

      // Reserved mtvec modes 2/3 fall through to the direct target.
      trap_tgt = {bus.csr_rd_mtvec_base, 2'b00};
`ifdef TRAP_VECTORED_EN
      if (bus.csr_rd_mtvec_mode == 2'd1 && intr_q)
         trap_tgt = trap_tgt + XLEN'({code_q, 2'b00});
`endif

      unique case (state_q)
         IDLE: begin
            if (bus.exc_valid) begin
               pc_d    = bus.exc_pc;
               code_d  = bus.exc_code;
               intr_d  = 1'b0;
               ret_d   = 1'b0;
               state_d = DRAIN;
            end else if (bus.mret_valid) begin
               ret_d   = 1'b1;
               state_d = DRAIN;
            end else if (bus.irq_valid) begin
               pc_d    = bus.next_pc;
               code_d  = bus.irq_code;
               intr_d  = 1'b1;
               ret_d   = 1'b0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!bus.pipe_busy)
               state_d = ret_q ? RETURN : SAVE;
         end
         SAVE: begin
            ent_trap = 1'b1;
            mepc_wr  = {pc_q[XLEN-1:2], 2'b00};
            code_wr  = code_q;
            intr_wr  = intr_q;
            state_d  = JUMP;
         end
         JUMP: begin
            rvalid = 1'b1;
            rpc    = trap_tgt;
            if (bus.redirect_ready)
               state_d = IDLE;
         end
         RETURN: begin
            rvalid = 1'b1;
            rpc    = {bus.csr_rd_mepc_mepc[XLEN-1:2], 2'b00};
            if (bus.redirect_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      stall_d = (state_d != IDLE);
   end

   assign bus.ent_trap                     = ent_trap;
   assign bus.csr_wr_mepc_mepc             = mepc_wr;
   assign bus.csr_wr_mcause_exception_code = code_wr;
   assign bus.csr_wr_mcause_interrupt      = intr_wr;
   assign bus.redirect_valid               = rvalid;
   assign bus.redirect_pc                  = rpc;
   assign bus.stall                        = stall_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed vector table, reset-abort sequence, randomized transactions vs. a transaction model.
module tb_trap_ctrl;
   logic clk = 1'b0;
   logic rst_b;
   always #5 clk = ~clk;

   trap_ctrl_if #(.XLEN(32)) b();
   trap_ctrl #(.XLEN(32)) dut (.clk(clk), .rst_b(rst_b), .bus(b));

`ifdef TRAP_VECTORED_EN
   localparam bit VEC = 1'b1;
`else
   localparam bit VEC = 1'b0;
`endif

   typedef struct {
      bit          exc, mret, irq, hold, chain;
      logic [30:0] ecode;
      logic [31:0] epc;
      logic [30:0] icode;
      logic [31:0] npc;
      int          busy, rwait;
      logic [29:0] base;
      logic [1:0]  mode;
      logic [31:0] mepc;
      bit          is_ret;
      logic [31:0] exp_pc;
      logic [30:0] exp_code;
      bit          exp_intr;
      logic [31:0] exp_rpc;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(bit exc, bit mret, bit irq, bit hold, bit chain,
                               logic [30:0] ecode, logic [31:0] epc, logic [30:0] icode,
                               logic [31:0] npc, int busy, int rwait, logic [29:0] base,
                               logic [1:0] mode, logic [31:0] mepc, bit is_ret,
                               logic [31:0] exp_pc, logic [30:0] exp_code, bit exp_intr,
                               logic [31:0] exp_rpc);
      vec_t v;
      v.exc = exc; v.mret = mret; v.irq = irq; v.hold = hold; v.chain = chain;
      v.ecode = ecode; v.epc = epc; v.icode = icode; v.npc = npc;
      v.busy = busy; v.rwait = rwait; v.base = base; v.mode = mode; v.mepc = mepc;
      v.is_ret = is_ret; v.exp_pc = exp_pc; v.exp_code = exp_code;
      v.exp_intr = exp_intr; v.exp_rpc = exp_rpc;
      return v;
   endfunction

   // Reference: what a trap/return transaction should produce, from priority and address rules.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      r.exp_pc = '0; r.exp_code = '0; r.exp_intr = 1'b0; r.is_ret = 1'b0;
      if (v.exc) begin
         r.exp_pc = v.epc & 32'hFFFF_FFFC; r.exp_code = v.ecode;
      end else if (v.mret) begin
         r.is_ret = 1'b1;
      end else begin
         r.exp_pc = v.npc & 32'hFFFF_FFFC; r.exp_code = v.icode; r.exp_intr = 1'b1;
      end
      if (r.is_ret)
         r.exp_rpc = v.mepc & 32'hFFFF_FFFC;
      else begin
         r.exp_rpc = 32'(v.base) * 32'd4;
         if (VEC && r.exp_intr && v.mode == 2'd1)
            r.exp_rpc = r.exp_rpc + 32'(r.exp_code) * 32'd4;
      end
      return r;
   endfunction

   task automatic run_txn(input vec_t v, input bit noise);
      int ent_c, rstart, idle_c;
      if (v.is_ret) begin ent_c = -1; rstart = 2 + v.busy; end
      else begin ent_c = 2 + v.busy; rstart = 3 + v.busy; end
      idle_c = rstart + v.rwait + 1;
      @(negedge clk);
      b.exc_valid = v.exc; b.exc_code = v.ecode; b.exc_pc = v.epc;
      b.mret_valid = v.mret; b.irq_valid = v.irq; b.irq_code = v.icode; b.next_pc = v.npc;
      b.pipe_busy = (v.busy > 0); b.redirect_ready = 1'b0;
      b.csr_rd_mtvec_base = v.base; b.csr_rd_mtvec_mode = v.mode; b.csr_rd_mepc_mepc = v.mepc;
      #1;
      chk("stall_accept", 32'(b.stall), 32'd0);
      for (int c = 1; c < idle_c; c++) begin
         @(negedge clk);
         b.exc_valid  = noise && ($urandom_range(0, 3) == 0);
         b.mret_valid = noise && ($urandom_range(0, 3) == 0);
         b.irq_valid  = v.hold || (noise && ($urandom_range(0, 1) == 0));
         if (noise) begin
            b.exc_pc = $urandom; b.exc_code = 31'($urandom);
            b.next_pc = $urandom; b.irq_code = 31'($urandom);
         end
         b.pipe_busy      = (c <= v.busy);
         b.redirect_ready = (c >= rstart + v.rwait);
         #1;
         chk($sformatf("stall_c%0d", c), 32'(b.stall), 32'd1);
         chk($sformatf("ent_trap_c%0d", c), 32'(b.ent_trap), 32'(c == ent_c));
         if (c == ent_c) begin
            chk("mepc_wr", b.csr_wr_mepc_mepc, v.exp_pc);
            chk("mcause_code", 32'(b.csr_wr_mcause_exception_code), 32'(v.exp_code));
            chk("mcause_intr", 32'(b.csr_wr_mcause_interrupt), 32'(v.exp_intr));
         end else begin
            chk("wr_data_idle", b.csr_wr_mepc_mepc | 32'(b.csr_wr_mcause_exception_code)
                                | 32'(b.csr_wr_mcause_interrupt), 32'd0);
         end
         chk($sformatf("rvalid_c%0d", c), 32'(b.redirect_valid), 32'(c >= rstart));
         if (c >= rstart)
            chk($sformatf("rpc_c%0d", c), b.redirect_pc, v.exp_rpc);
      end
   endtask

   task automatic idle_chk();
      @(negedge clk);
      b.exc_valid = 1'b0; b.mret_valid = 1'b0; b.irq_valid = 1'b0;
      b.pipe_busy = 1'b0; b.redirect_ready = 1'b1;
      #1;
      chk("idle_stall", 32'(b.stall), 32'd0);
      chk("idle_out", 32'(b.redirect_valid) | 32'(b.ent_trap), 32'd0);
   endtask

   vec_t tbl[11];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = mk(1,0,0,0,0, 31'd11, 32'h8000_0040, 31'd0, 32'h0, 0, 0, 30'h2000_0040, 2'd0, 32'h0,
                   0, 32'h8000_0040, 31'd11, 0, 32'h8000_0100);
      tbl[1]  = mk(1,0,0,0,0, 31'd11, 32'h8000_0040, 31'd0, 32'h0, 5, 0, 30'h2000_0040, 2'd0, 32'h0,
                   0, 32'h8000_0040, 31'd11, 0, 32'h8000_0100);
      tbl[2]  = mk(0,1,0,0,0, 31'd0, 32'h0, 31'd0, 32'h0, 0, 0, 30'h2000_0040, 2'd0, 32'h8000_0044,
                   1, 32'h0, 31'd0, 0, 32'h8000_0044);
      tbl[3]  = mk(1,1,1,1,1, 31'd2, 32'h8000_0200, 31'd7, 32'h8000_0300, 0, 0, 30'h2000_0040, 2'd0, 32'h0,
                   0, 32'h8000_0200, 31'd2, 0, 32'h8000_0100);
      tbl[4]  = mk(0,0,1,0,0, 31'd0, 32'h0, 31'd7, 32'h8000_0300, 0, 0, 30'h2000_0040, 2'd1, 32'h0,
                   0, 32'h8000_0300, 31'd7, 1, VEC ? 32'h8000_011C : 32'h8000_0100);
      tbl[5]  = mk(1,0,0,0,0, 31'd0, 32'h0000_0003, 31'd0, 32'h0, 1, 4, 30'h0, 2'd0, 32'h0,
                   0, 32'h0, 31'd0, 0, 32'h0);
      tbl[6]  = mk(0,1,0,0,0, 31'd0, 32'h0, 31'd0, 32'h0, 0, 2, 30'h0, 2'd0, 32'hFFFF_FFFF,
                   1, 32'h0, 31'd0, 0, 32'hFFFF_FFFC);
      tbl[7]  = mk(0,0,1,0,0, 31'd0, 32'h0, 31'h10, 32'h1234_5677, 2, 1, 30'h3FFF_FFFF, 2'd1, 32'h0,
                   0, 32'h1234_5674, 31'h10, 1, VEC ? 32'h0000_003C : 32'hFFFF_FFFC);
      tbl[8]  = mk(1,0,0,0,0, 31'd5, 32'h8000_0010, 31'd0, 32'h0, 0, 0, 30'h2000_0040, 2'd1, 32'h0,
                   0, 32'h8000_0010, 31'd5, 0, 32'h8000_0100);
      tbl[9]  = mk(0,0,1,0,0, 31'd0, 32'h0, 31'd3, 32'h0000_1000, 0, 0, 30'h2000_0040, 2'd3, 32'h0,
                   0, 32'h0000_1000, 31'd3, 1, 32'h8000_0100);
      tbl[10] = mk(0,1,1,0,0, 31'd0, 32'h0, 31'd9, 32'h0000_2000, 1, 0, 30'h2000_0040, 2'd0, 32'h0000_1000,
                   1, 32'h0, 31'd0, 0, 32'h0000_1000);

      rst_b = 1'b0;
      b.exc_valid = 1'b0; b.exc_code = '0; b.exc_pc = '0; b.mret_valid = 1'b0;
      b.irq_valid = 1'b0; b.irq_code = '0; b.next_pc = '0; b.pipe_busy = 1'b0;
      b.csr_rd_mtvec_base = '0; b.csr_rd_mtvec_mode = '0; b.csr_rd_mepc_mepc = '0;
      b.redirect_ready = 1'b0;
      #3;
      chk("rst_stall", 32'(b.stall), 32'd0);
      chk("rst_ent", 32'(b.ent_trap), 32'd0);
      chk("rst_rvalid", 32'(b.redirect_valid), 32'd0);
      chk("rst_rpc", b.redirect_pc, 32'd0);
      chk("rst_mepc", b.csr_wr_mepc_mepc, 32'd0);
      @(negedge clk);
      rst_b = 1'b1;

      foreach (tbl[i]) begin
         run_txn(tbl[i], 1'b0);
         if (!tbl[i].chain) idle_chk();
      end

      // Reset while holding a redirect in JUMP must drop everything at once.
      @(negedge clk);
      b.exc_valid = 1'b1; b.exc_code = 31'd1; b.exc_pc = 32'h40;
      b.csr_rd_mtvec_base = 30'h2000_0040; b.csr_rd_mtvec_mode = 2'd0;
      b.pipe_busy = 1'b0; b.redirect_ready = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         b.exc_valid = 1'b0;
         #1;
         if (c == 2) chk("rstseq_ent", 32'(b.ent_trap), 32'd1);
         if (c >= 3) chk("rstseq_rvalid", 32'(b.redirect_valid), 32'd1);
      end
      rst_b = 1'b0;
      #1;
      chk("midrst_rvalid", 32'(b.redirect_valid), 32'd0);
      chk("midrst_rpc", b.redirect_pc, 32'd0);
      chk("midrst_stall", 32'(b.stall), 32'd0);
      chk("midrst_ent", 32'(b.ent_trap), 32'd0);
      @(negedge clk);
      rst_b = 1'b1; b.redirect_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         chk("postrst_quiet", 32'(b.stall) | 32'(b.ent_trap) | 32'(b.redirect_valid), 32'd0);
      end

      for (int n = 0; n < 40; n++) begin
         vec_t v;
         logic [2:0] k;
         k = 3'($urandom_range(1, 7));
         v.exc = k[0]; v.mret = k[1]; v.irq = k[2]; v.hold = 1'b0; v.chain = 1'b0;
         v.ecode = 31'($urandom); v.epc = $urandom;
         v.icode = 31'($urandom_range(0, 63)); v.npc = $urandom;
         v.busy = $urandom_range(0, 3); v.rwait = $urandom_range(0, 3);
         v.base = 30'($urandom); v.mode = 2'($urandom_range(0, 3)); v.mepc = $urandom;
         v = model(v);
         run_txn(v, 1'b1);
         idle_chk();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
